// File: rtl/dotproduct_pkg.sv
// Shared types and size helpers for the fixed-latency sign-magnitude dot-product MAC.
package dotproduct_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic int beats(input int h, input int l);
        return (h + l - 1) / l;
    endfunction

    // Width of one truncated product in two's complement (magnitude bits + sign)
    function automatic int prod_w(input int n, input int q);
        return 2 * (n - 1) - q + 1;
    endfunction

    function automatic int acc_w(input int n, input int q, input int h);
        return 2 * (n - 1) - q + $clog2(h) + 1;
    endfunction

endpackage

// File: rtl/smag_mult_lane.sv
// One combinational multiply lane: sign-magnitude in, Q-truncated two's-complement product out.
module smag_mult_lane
    import dotproduct_pkg::*;
#(
    parameter int Q  = 15,
    parameter int N  = 32,
    parameter int PW = prod_w(N, Q)
) (
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    output logic [PW-1:0] p
);

    localparam int MW = 2 * (N - 1);

    logic [MW-1:0] full;
    logic [PW-1:0] mag;

    assign full = {{(N-1){1'b0}}, a[N-2:0]} * {{(N-1){1'b0}}, b[N-2:0]};
    assign mag  = PW'(full >> Q);
    // Negating a zero magnitude yields zero, so -0 never reaches the accumulator
    assign p    = (a[N-1] ^ b[N-1]) ? -mag : mag;

endmodule

// File: rtl/dotproduct_mac.sv
// Dot product of two H-element sign-magnitude vectors, L lanes per beat,
// fixed latency BEATS+2 from the accepting edge to the done pulse.
module dotproduct_mac
    import dotproduct_pkg::*;
#(
    parameter int Q = 15,
    parameter int N = 32,
    parameter int H = 10,
    parameter int L = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a_vec [H],
    input  logic [N-1:0] b_vec [H],
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         overflow
);

    localparam int BEATS = beats(H, L);
    localparam int PW    = prod_w(N, Q);
    localparam int ACC_W = acc_w(N, Q, H);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t                    state;
    logic [CW-1:0]             beat;
    logic                      accept;
    logic [N-1:0]              a_q [H];
    logic [N-1:0]              b_q [H];
    logic [L-1:0][N-1:0]       lane_a, lane_b;
    logic [L-1:0][PW-1:0]      lane_p, prod_q;
    logic                      prod_vld;
    logic signed [ACC_W-1:0]   acc, lane_sum;
    logic [ACC_W-1:0]          mag;
    logic                      sat;

    assign accept = start && (state == IDLE || state == DONE);

    for (genvar j = 0; j < L; j++) begin : g_lane
        int idx;
        // Lanes past the end of the vector on the last beat see zero operands
        always_comb begin
            idx       = int'(beat) * L + j;
            lane_a[j] = '0;
            lane_b[j] = '0;
            for (int i = 0; i < H; i++) begin
                if (i == idx) begin
                    lane_a[j] = a_q[i];
                    lane_b[j] = b_q[i];
                end
            end
        end

        smag_mult_lane #(.Q(Q), .N(N), .PW(PW)) u_mul (
            .a (lane_a[j]),
            .b (lane_b[j]),
            .p (lane_p[j])
        );
    end

    always_comb begin
        lane_sum = '0;
        for (int j = 0; j < L; j++)
            lane_sum = lane_sum + ACC_W'($signed(prod_q[j]));
    end

    assign mag = acc[ACC_W-1] ? -acc : acc;
    assign sat = |mag[ACC_W-1:N-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            beat  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    beat  <= '0;
                    busy  <= 1'b1;
                end
                RUN: begin
                    if (beat == CW'(BEATS - 1)) state <= DRAIN;
                    else                        beat  <= beat + 1'b1;
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                end
                DONE: begin
                    done <= 1'b1;
                    if (start) begin
                        state <= RUN;
                        beat  <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a_vec;
            b_q <= b_vec;
        end
    end

    // Stage 1 registers lane products, stage 2 folds them into the accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q   <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            prod_q   <= lane_p;
            prod_vld <= (state == RUN);
            if (accept)        acc <= '0;
            else if (prod_vld) acc <= acc + lane_sum;
            if (state == DONE) begin
                result   <= sat ? {acc[ACC_W-1], {(N-1){1'b1}}} : {acc[ACC_W-1], mag[N-2:0]};
                overflow <= sat;
            end
        end
    end

endmodule
